dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory responder: one request at a time, LATENCY wait
// cycles, then a single-cycle response strobe. Storage survives reset.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | counting down the inserted wait cycles
    // RESP  | one-cycle completion strobe
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, enter_resp, addr_err;
    logic        eff_write;
    logic [31:0] eff_addr, eff_wdata;
    logic [3:0]  eff_be;
    logic [AW-1:0] idx;

    assign req_ready  = (state_q == IDLE) && reset_n;
    assign busy       = (state_q == WAIT) || (state_q == RESP);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    // With zero latency the access happens on the accept edge, so use live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            eff_write = req_write;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_be    = req_byte_en;
        end else begin
            eff_write = write_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_be    = be_q;
        end
    end

    assign addr_err = (eff_addr[1:0] != 2'b00) || (eff_addr[31:AW+2] != '0);
    assign idx      = eff_addr[AW+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                // Leave on the edge that brings the counter to zero: LATENCY WAIT cycles.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_byte_en;
            end
            if (enter_resp) begin
                err_q   <= addr_err;
                rdata_q <= (addr_err || eff_write) ? 32'd0 : mem_q[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enter_resp && eff_write && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) mem_q[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 2, 0, 4) sharing clock, reset and request fields.
module tb_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic [2:0]  vld;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rdy [3];
    logic        rv  [3];
    logic        bsy [3];
    logic        er  [3];
    logic [31:0] rd  [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clock(clk), .reset_n(rst_n), .req_valid(vld[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_be),
        .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bsy[0]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_l0 (
        .clock(clk), .reset_n(rst_n), .req_valid(vld[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_be),
        .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bsy[1]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
        .clock(clk), .reset_n(rst_n), .req_valid(vld[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_be),
        .req_ready(rdy[2]), .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2]), .busy(bsy[2]));

    // One transaction; lat = negedges from acceptance until resp_valid is seen (capped at 40).
    task automatic xact(input int sel, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int lat, output logic [31:0] data, output logic e);
        @(negedge clk);
        vld[sel] = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
        @(negedge clk);
        vld[sel] = 1'b0; req_wdata = 32'hA5A5A5A5; req_addr = 32'hFFFF_FFFF;
        lat = 1;
        while (!rv[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        data = rd[sel];
        e    = er[sel];
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #6;
        checks++; if (rv[0] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", rv[0]); end
        checks++; if (rd[0] !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", rd[0]); end
        checks++; if (er[0] !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", er[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bsy[0]); end
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", rdy[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", rdy[0]); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] d; logic e;
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got=%0d exp=3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err got=%b exp=0", e); end
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, d, e);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got=%h exp=deadbeef", d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
        // Response fields must hold after the strobe.
        repeat (3) @(negedge clk);
        checks++; if (rd[0] !== 32'hDEADBEEF || rv[0] !== 1'b0) begin
            errors++; $display("FAIL rdata_hold got=%h/%b exp=deadbeef/0", rd[0], rv[0]); end
        xact(0, 1'b1, 32'h3FC, 32'h600DF00D, 4'hF, lat, d, e);
        xact(0, 1'b0, 32'h3FC, 32'h0, 4'hF, lat, d, e);
        checks++; if (d !== 32'h600DF00D || e !== 1'b0) begin
            errors++; $display("FAIL last_word got=%h/%b exp=600df00d/0", d, e); end
    endtask

    task automatic test_partial();
        int lat; logic [31:0] d; logic e;
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, d, e);
        xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, lat, d, e);
        xact(0, 1'b0, 32'h20, 32'hFFFFFFFF, 4'h1, lat, d, e);
        checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL partial_store got=%h exp=11bb33dd", d); end
        xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, d, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be_zero_err got=%b exp=0", e); end
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, d, e);
        checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_nochange got=%h exp=11bb33dd", d); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] d; logic e;
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, d, e);
        xact(0, 1'b0, 32'h22, 32'h0, 4'hF, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL misaligned_load got=%b/%h exp=1/0", e, d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL err_latency got=%0d exp=3", lat); end
        xact(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, d, e);
        xact(0, 1'b1, 32'h400, 32'h12345678, 4'hF, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL oob_store got=%b/%h exp=1/0", e, d); end
        xact(0, 1'b1, 32'h12, 32'h0, 4'hF, lat, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_store got=%b exp=1", e); end
        xact(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, d, e);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL oob_no_alias got=%h exp=cafef00d", d); end
        xact(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, d, e);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_no_write got=%h exp=deadbeef", d); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; logic e;
        logic [31:0] words [3];
        int bad;
        words[0] = 32'h01010101; words[1] = 32'h02020202; words[2] = 32'h03030303;
        for (int k = 0; k < 3; k++) xact(1, 1'b1, 32'(4*k), words[k], 4'hF, lat, d, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL l0_latency got=%0d exp=1", lat); end
        @(negedge clk);
        vld[1] = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bad = 0;
            if (rv[1] !== (i % 2 == 0)) bad = 1;
            if (rdy[1] !== (i % 2 == 1)) bad = 1;
            if (bsy[1] !== (i % 2 == 0)) bad = 1;
            if (i % 2 == 0 && rd[1] !== words[i/2]) bad = 1;
            checks++; if (bad != 0) begin errors++;
                $display("FAIL b2b_cycle%0d got rv=%b rdy=%b busy=%b rdata=%h exp rv=%0d rdy=%0d busy=%0d",
                         i, rv[1], rdy[1], bsy[1], rd[1], (i % 2 == 0), (i % 2 == 1), (i % 2 == 0)); end
            if (i == 0 || i == 2) req_addr = 32'(4*(i/2 + 1));
            if (i == 4) vld[1] = 1'b0;
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] d; logic e;
        int seen;
        xact(2, 1'b1, 32'h30, 32'h0BADCAFE, 4'hF, lat, d, e);
        checks++; if (lat !== 5) begin errors++; $display("FAIL l4_latency got=%0d exp=5", lat); end
        seen = 0;
        @(negedge clk);
        vld[2] = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        @(negedge clk);
        vld[2] = 1'b0;
        if (rv[2]) seen++;
        @(negedge clk);
        if (rv[2]) seen++;
        rst_n = 1'b0;
        repeat (2) begin @(negedge clk); if (rv[2]) seen++; end
        rst_n = 1'b1;
        #1;
        checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL ready_after_abort got=%b exp=1", rdy[2]); end
        repeat (6) begin @(negedge clk); if (rv[2]) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_resp got=%0d strobes exp=0", seen); end
        xact(2, 1'b0, 32'h30, 32'h0, 4'hF, lat, d, e);
        checks++; if (d !== 32'h0BADCAFE) begin errors++; $display("FAIL abort_store_discarded got=%h exp=0badcafe", d); end
    endtask

    initial begin
        vld = 3'b000; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        test_reset();
        test_store_load();
        test_partial();
        test_errors();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
